filter_event_ctrl: RTL and testbench

Event controller for the pulse-shaping filter output. Watches the signed filtered stream every clock and arms on a threshold crossing. It tracks the pulse maximum and its timestamp, enforces a programmable hold-off (dead time), and hands each event to the readout through a one-deep valid/ready output register. Events that close while the register is still occupied are counted as drops, and over-long pulses are flagged as pile-up.

---
 rtl/filter_event_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_filter_event_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_event_ctrl.sv
// -----------------------------------------------------------------------------
// filter_event_ctrl
//
// Event controller for the pulse-shaping filter output. It watches the signed
// filtered stream and arms when the stream crosses the threshold. While armed
// it tracks the pulse maximum and the timestamp of that maximum. When the
// pulse falls back it closes the event, hands it to a one-deep valid/ready
// output register, then enforces a programmable hold-off (dead time).
//
// Ports
//   clk         in   system clock, all logic on the rising edge
//   reset       in   asynchronous, active-low; clears all state and outputs
//   filt_data   in   signed filter sample, one per clock
//   threshold   in   signed trigger level (quasi-static)
//   holdoff     in   dead time in clocks after an event closes
//   enable      in   arming enable; dropping it during a pulse aborts it
//   ev_valid    out  output register holds an event
//   ev_ready    in   consumer accepts the event on this edge
//   ev_amp      out  signed peak amplitude of the event
//   ev_time     out  timestamp of the peak sample
//   ev_pileup   out  pulse stayed above threshold for MAX_RISE or more cycles
//   busy        out  controller is not idle (decoded from the state register)
//   drop_count  out  events lost to a full output register, saturating
// -----------------------------------------------------------------------------
module filter_event_ctrl #(
  parameter int DATA_W   = 16,
  parameter int TS_W     = 32,
  parameter int MAX_RISE = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filt_data,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic        [15:0]       holdoff,
  input  logic                     enable,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic signed [DATA_W-1:0] ev_amp,
  output logic        [TS_W-1:0]   ev_time,
  output logic                     ev_pileup,
  output logic                     busy,
  output logic        [15:0]       drop_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RISE = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam int                RISE_W   = $clog2(MAX_RISE + 1);
  localparam logic [RISE_W-1:0] RISE_MAX = RISE_W'(MAX_RISE);

  logic [1:0]               state_q,    state_d;
  logic [TS_W-1:0]          ts_q;
  logic signed [DATA_W-1:0] peak_q,     peak_d;
  logic [TS_W-1:0]          peak_ts_q,  peak_ts_d;
  logic [RISE_W-1:0]        rise_cnt_q, rise_cnt_d;
  logic                     pile_q,     pile_d;
  logic [15:0]              hold_cnt_q, hold_cnt_d;

  logic                     ev_valid_q,  ev_valid_d;
  logic signed [DATA_W-1:0] ev_amp_q,    ev_amp_d;
  logic [TS_W-1:0]          ev_time_q,   ev_time_d;
  logic                     ev_pileup_q, ev_pileup_d;
  logic [15:0]              drop_q,      drop_d;

  logic above;
  logic close_ev;
  logic reg_free;

  // Both operands are signed, so this is a signed, strict comparison.
  assign above = filt_data > threshold;

  // ---------------------------------------------------------------------------
  // Event FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    peak_d     = peak_q;
    peak_ts_d  = peak_ts_q;
    rise_cnt_d = rise_cnt_q;
    pile_d     = pile_q;
    hold_cnt_d = hold_cnt_q;
    close_ev   = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && above) begin
          state_d    = RISE;
          peak_d     = filt_data;
          peak_ts_d  = ts_q;
          rise_cnt_d = RISE_W'(1);
          pile_d     = 1'b0;
        end
      end

      RISE: begin
        if (!enable) begin
          // Abort: the pulse is discarded, nothing is emitted or counted.
          state_d = IDLE;
        end else if (!above) begin
          close_ev = 1'b1;
          if (holdoff == 16'd0) begin
            state_d = IDLE;
          end else begin
            state_d    = HOLD;
            hold_cnt_d = holdoff;
          end
        end else begin
          // Strict compare keeps the first sample of a flat-topped peak.
          if (filt_data > peak_q) begin
            peak_d    = filt_data;
            peak_ts_d = ts_q;
          end
          if (rise_cnt_q < RISE_MAX) begin
            rise_cnt_d = rise_cnt_q + 1'b1;
          end
          if (rise_cnt_d == RISE_MAX) begin
            pile_d = 1'b1;
          end
        end
      end

      HOLD: begin
        // Counter holds the remaining HOLD cycles including this one, so the
        // state lasts exactly holdoff clocks.
        if (hold_cnt_q <= 16'd1) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One-deep output register and drop counter
  // ---------------------------------------------------------------------------
  // The register is free when empty or when its content leaves on this edge.
  assign reg_free = !ev_valid_q || ev_ready;

  always_comb begin
    ev_valid_d  = ev_valid_q;
    ev_amp_d    = ev_amp_q;
    ev_time_d   = ev_time_q;
    ev_pileup_d = ev_pileup_q;
    drop_d      = drop_q;

    if (close_ev && reg_free) begin
      ev_valid_d  = 1'b1;
      ev_amp_d    = peak_q;
      ev_time_d   = peak_ts_q;
      ev_pileup_d = pile_q;
    end else if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end

    if (close_ev && !reg_free && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ts_q        <= '0;
      peak_q      <= '0;
      peak_ts_q   <= '0;
      rise_cnt_q  <= '0;
      pile_q      <= 1'b0;
      hold_cnt_q  <= '0;
      ev_valid_q  <= 1'b0;
      ev_amp_q    <= '0;
      ev_time_q   <= '0;
      ev_pileup_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_q + 1'b1;
      peak_q      <= peak_d;
      peak_ts_q   <= peak_ts_d;
      rise_cnt_q  <= rise_cnt_d;
      pile_q      <= pile_d;
      hold_cnt_q  <= hold_cnt_d;
      ev_valid_q  <= ev_valid_d;
      ev_amp_q    <= ev_amp_d;
      ev_time_q   <= ev_time_d;
      ev_pileup_q <= ev_pileup_d;
      drop_q      <= drop_d;
    end
  end

  assign ev_valid   = ev_valid_q;
  assign ev_amp     = ev_amp_q;
  assign ev_time    = ev_time_q;
  assign ev_pileup  = ev_pileup_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_filter_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_filter_event_ctrl
//
// Directed bench for filter_event_ctrl. The DUT is built with an 8-bit
// timestamp so the wrap from all-ones to zero is reached quickly, and with
// MAX_RISE = 4 for the pile-up cases. ts_now is the timestamp the DUT applies
// to the sample presented on the next rising edge.
// -----------------------------------------------------------------------------
module tb_filter_event_ctrl;

  localparam int DATA_W   = 16;
  localparam int TS_W     = 8;
  localparam int MAX_RISE = 4;

  logic                     clk;
  logic                     reset;
  logic signed [DATA_W-1:0] filt_data;
  logic signed [DATA_W-1:0] threshold;
  logic        [15:0]       holdoff;
  logic                     enable;
  logic                     ev_valid;
  logic                     ev_ready;
  logic signed [DATA_W-1:0] ev_amp;
  logic        [TS_W-1:0]   ev_time;
  logic                     ev_pileup;
  logic                     busy;
  logic        [15:0]       drop_count;

  int checks = 0;
  int errors = 0;
  int ts_now = 0;
  int t_peak = 0;

  filter_event_ctrl #(
    .DATA_W  (DATA_W),
    .TS_W    (TS_W),
    .MAX_RISE(MAX_RISE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .filt_data (filt_data),
    .threshold (threshold),
    .holdoff   (holdoff),
    .enable    (enable),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_amp    (ev_amp),
    .ev_time   (ev_time),
    .ev_pileup (ev_pileup),
    .busy      (busy),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and sample outputs just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    ts_now = (ts_now + 1) % 256;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    filt_data = '0;
    threshold = 16'sd100;
    holdoff   = 16'd10;
    ev_ready  = 1'b1;

    // ---------------- reset values
    #12;
    check("rst_valid", ev_valid, 0);
    check("rst_amp", ev_amp, 0);
    check("rst_time", ev_time, 0);
    check("rst_pileup", ev_pileup, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    #5;
    reset  = 1'b1;
    ts_now = 0;
    enable = 1'b1;

    // ---------------- single pulse: 0,150,300,250,50 from ts 20
    while (ts_now != 20) tick();
    filt_data = 0;   tick();
    check("sp_idle_busy", busy, 0);
    filt_data = 150; tick();
    check("sp_trig_busy", busy, 1);
    check("sp_trig_valid", ev_valid, 0);
    filt_data = 300; tick();
    filt_data = 250; tick();
    filt_data = 50;  tick();             // close at ts 24
    check("sp_valid", ev_valid, 1);
    check("sp_amp", ev_amp, 300);
    check("sp_time", ev_time, 22);
    check("sp_pileup", ev_pileup, 0);
    check("sp_hold_busy", busy, 1);
    filt_data = 0;   tick();             // close + 1
    check("sp_valid_one_clk", ev_valid, 0);

    // ---------------- hold-off: pulse at close+5 ignored, close+11 taken
    repeat (3) tick();                   // close + 4
    filt_data = 200; tick();             // close + 5, inside hold-off
    check("ho_ignored_busy", busy, 1);
    filt_data = 0;   tick();             // close + 6
    check("ho_ignored_valid", ev_valid, 0);
    repeat (3) tick();                   // close + 9
    check("ho_last_hold", busy, 1);
    tick();                              // close + 10
    check("ho_idle", busy, 0);
    filt_data = 200; tick();             // close + 11, ts 35
    check("ho_retrig", busy, 1);
    filt_data = 0;   tick();
    check("ho_valid", ev_valid, 1);
    check("ho_amp", ev_amp, 200);
    check("ho_time", ev_time, 35);
    check("ho_drop", drop_count, 0);
    repeat (11) tick();
    check("ho_done_busy", busy, 0);
    check("ho_done_valid", ev_valid, 0);

    // ---------------- back-pressure, holdoff 0, three pulses
    ev_ready = 1'b0;
    holdoff  = 16'd0;
    filt_data = 120; tick();
    filt_data = 180; t_peak = ts_now; tick();
    filt_data = 0;   tick();
    check("bp_valid1", ev_valid, 1);
    check("bp_amp1", ev_amp, 180);
    check("bp_time1", ev_time, t_peak);
    filt_data = 400; tick();
    filt_data = 0;   tick();
    check("bp_drop1", drop_count, 1);
    check("bp_amp_stable", ev_amp, 180);
    check("bp_time_stable", ev_time, t_peak);
    check("bp_valid_stable", ev_valid, 1);
    filt_data = 250; tick();
    filt_data = 0;   tick();
    check("bp_drop2", drop_count, 2);
    check("bp_amp_stable2", ev_amp, 180);
    ev_ready = 1'b1; tick();
    check("bp_accept", ev_valid, 0);

    // ---------------- transfer and load on the same edge
    ev_ready  = 1'b0;
    filt_data = 130; tick();
    filt_data = 0;   tick();
    check("tl_first_amp", ev_amp, 130);
    filt_data = 140; t_peak = ts_now; tick();
    ev_ready  = 1'b1;
    filt_data = 0;   tick();
    check("tl_valid", ev_valid, 1);
    check("tl_amp", ev_amp, 140);
    check("tl_time", ev_time, t_peak);
    check("tl_drop", drop_count, 2);
    tick();
    check("tl_drain", ev_valid, 0);

    // ---------------- pile-up and plateau
    filt_data = 500; t_peak = ts_now;
    repeat (6) tick();
    filt_data = 0;   tick();
    check("pu_amp", ev_amp, 500);
    check("pu_time", ev_time, t_peak);
    check("pu_pileup", ev_pileup, 1);
    filt_data = 600; repeat (4) tick();
    filt_data = 0;   tick();
    check("pu_exact4", ev_pileup, 1);
    filt_data = 700; repeat (3) tick();
    filt_data = 0;   tick();
    check("pu_3_amp", ev_amp, 700);
    check("pu_3_pileup", ev_pileup, 0);
    tick();
    check("pu_drain", ev_valid, 0);

    // ---------------- enable abort
    filt_data = 300; tick();
    check("ab_busy", busy, 1);
    enable = 1'b0;   tick();
    check("ab_idle", busy, 0);
    filt_data = 0;   tick();
    check("ab_no_event", ev_valid, 0);
    check("ab_drop", drop_count, 2);
    enable = 1'b1;

    // ---------------- reset during RISE
    filt_data = 300; tick();
    check("rr_busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    check("rr_busy0", busy, 0);
    check("rr_valid0", ev_valid, 0);
    check("rr_drop0", drop_count, 0);
    check("rr_amp0", ev_amp, 0);
    check("rr_time0", ev_time, 0);
    check("rr_pile0", ev_pileup, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    ts_now = 0;
    filt_data = 200; tick();             // ts 0
    filt_data = 0;   tick();
    check("rr_ts_restart_valid", ev_valid, 1);
    check("rr_ts_restart_time", ev_time, 0);
    check("rr_ts_restart_amp", ev_amp, 200);

    // ---------------- negative threshold
    threshold = -16'sd50;
    filt_data = -16'sd50; tick();
    check("ng_equal_no_trig", busy, 0);
    filt_data = -16'sd40; t_peak = ts_now; tick();
    check("ng_trig", busy, 1);
    filt_data = -16'sd60; tick();
    check("ng_valid", ev_valid, 1);
    check("ng_amp", ev_amp, -40);
    check("ng_time", ev_time, t_peak);

    // ---------------- timestamp wrap, peak on ts 0, close on equal sample
    filt_data = -16'sd100;
    while (ts_now != 254) tick();
    filt_data = -16'sd45; tick();        // ts 254
    filt_data = -16'sd30; tick();        // ts 255
    filt_data = -16'sd5;  tick();        // ts 0
    filt_data = -16'sd50; tick();        // equal to threshold: closes
    check("wr_valid", ev_valid, 1);
    check("wr_amp", ev_amp, -5);
    check("wr_time", ev_time, 0);
    check("wr_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
